cpu_decode_stage: RTL

- Registered instruction-decode pipeline stage between fetch and execute.
- Decodes R, I, J formats with a valid/ready handshake on both sides.
- A register scoreboard stalls read-after-write hazards; a small FSM squashes wrong-path instructions after a jump until fetch confirms the redirect.
- Successor to the combinational decoder. Adds a configurable immediate extension, JAL, store/branch source handling, a delay-slot mode and pipelining.

---
 rtl/cpu_decode_stage_if.sv | 40 ++++
 rtl/cpu_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode_stage_if.sv
// Fetch/execute/writeback signal bundle for the decode stage.
// The stage itself connects through the slave modport.
interface cpu_decode_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [4:0]        out_src1;
  logic [4:0]        out_src2;
  logic              out_src2_used;
  logic [4:0]        out_dst;
  logic              out_dst_used;
  logic [DATA_W-1:0] out_imm;
  logic              out_use_imm;
  logic              out_do_jump;
  logic [DATA_W-1:0] out_jump_addr;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic              flush;
  logic              hazard_stall;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_reg, flush,
    input  in_ready, out_valid, out_pc, out_src1, out_src2, out_src2_used,
           out_dst, out_dst_used, out_imm, out_use_imm, out_do_jump,
           out_jump_addr, hazard_stall
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_reg, flush,
    output in_ready, out_valid, out_pc, out_src1, out_src2, out_src2_used,
           out_dst, out_dst_used, out_imm, out_use_imm, out_do_jump,
           out_jump_addr, hazard_stall
  );
endinterface

// File: rtl/cpu_decode_stage.sv
// Registered R/I/J instruction decoder with a RAW scoreboard and
// wrong-path squashing after jumps until fetch flushes.
module cpu_decode_stage #(
  parameter int unsigned DATA_W        = 32,
  parameter bit          IMM_SIGN_EXT  = 1'b1,
  parameter bit          DELAY_SLOT    = 1'b0,
  parameter bit          SCOREBOARD_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  cpu_decode_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SLOT,
    ST_SQUASH
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [5:0]        w_opcode;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [15:0]       w_imm16;
  logic [4:0]        w_src1;
  logic [4:0]        w_src2;
  logic              w_src2_used;
  logic [4:0]        w_dst;
  logic              w_dst_wr;
  logic              w_dst_used;
  logic              w_use_imm;
  logic              w_do_jump;
  logic              w_zero_ext;
  logic [DATA_W-1:0] w_imm;
  logic [3:0]        w_pc4_hi;
  logic [DATA_W-1:0] w_jump_addr;

  logic [31:0]       r_busy;
  logic [31:0]       w_wb_mask;
  logic [31:0]       w_set_mask;
  logic [31:0]       w_held_mask;
  logic [31:0]       w_block;
  logic              w_conflict;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_out_hs;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_pc;
  logic [4:0]        r_out_src1;
  logic [4:0]        r_out_src2;
  logic              r_out_src2_used;
  logic [4:0]        r_out_dst;
  logic              r_out_dst_used;
  logic [DATA_W-1:0] r_out_imm;
  logic              r_out_use_imm;
  logic              r_out_do_jump;
  logic [DATA_W-1:0] r_out_jump_addr;

  assign w_opcode = bus.in_instr[31:26];
  assign w_rs     = bus.in_instr[25:21];
  assign w_rt     = bus.in_instr[20:16];
  assign w_rd     = bus.in_instr[15:11];
  assign w_imm16  = bus.in_instr[15:0];

  always_comb begin
    w_src1      = w_rs;
    w_src2      = w_rt;
    w_src2_used = 1'b0;
    w_dst       = '0;
    w_dst_wr    = 1'b0;
    w_use_imm   = 1'b1;
    w_do_jump   = 1'b0;
    case (w_opcode)
      6'b000000: begin
        w_src2_used = 1'b1;
        w_dst       = w_rd;
        w_dst_wr    = 1'b1;
        w_use_imm   = 1'b0;
      end
      6'b000010, 6'b000011: begin
        w_src1    = '0;
        w_src2    = '0;
        w_use_imm = 1'b0;
        w_do_jump = 1'b1;
        if (w_opcode[0]) begin
          w_dst    = 5'd31;
          w_dst_wr = 1'b1;
        end
      end
      default: begin
        if (w_opcode[5:2] == 4'b0001 || w_opcode[5:3] == 3'b101) begin
          w_src2_used = 1'b1;
        end else begin
          w_dst    = w_rt;
          w_dst_wr = 1'b1;
        end
      end
    endcase
  end

  assign w_dst_used = w_dst_wr && (w_dst != 5'd0);

  always_comb begin
    w_zero_ext = !IMM_SIGN_EXT || (w_opcode inside {6'b001100, 6'b001101, 6'b001110});
    w_imm      = '0;
    w_imm[15:0] = w_imm16;
    if (!w_zero_ext && w_imm16[15]) begin
      w_imm[DATA_W-1:16] = '1;
    end
  end

  // Only the top nibble of pc+4 is needed: it carries iff pc[27:2] is all ones.
  assign w_pc4_hi = bus.in_pc[31:28] + {3'b000, &bus.in_pc[27:2]};

  always_comb begin
    w_jump_addr       = '0;
    w_jump_addr[31:0] = {w_pc4_hi, bus.in_instr[25:0], 2'b00};
  end

  // Writeback in the same cycle frees the register early (bypass).
  assign w_wb_mask   = bus.wb_valid ? (32'd1 << bus.wb_reg) : '0;
  assign w_out_hs    = r_out_valid && bus.out_ready;
  assign w_set_mask  = (w_out_hs && r_out_dst_used) ? (32'd1 << r_out_dst) : '0;
  assign w_held_mask = (r_out_valid && r_out_dst_used) ? (32'd1 << r_out_dst) : '0;
  assign w_block     = ((r_busy & ~w_wb_mask) | w_held_mask) & 32'hFFFF_FFFE;
  assign w_conflict  = w_block[w_src1] || (w_src2_used && w_block[w_src2]);
  assign w_hazard    = SCOREBOARD_EN && bus.in_valid && (r_state != ST_SQUASH) && w_conflict;

  always_comb begin
    if (bus.flush) begin
      w_in_ready = 1'b0;
    end else if (r_state == ST_SQUASH) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_load   = w_accept && (r_state != ST_SQUASH);

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_do_jump) begin
            w_state_next = DELAY_SLOT ? ST_SLOT : ST_SQUASH;
          end
        end
        ST_SLOT: begin
          if (w_accept) begin
            w_state_next = ST_SQUASH;
          end
        end
        default: w_state_next = ST_SQUASH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Set applied after clear so a same-cycle set of the same register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wb_mask) | w_set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_pc        <= '0;
      r_out_src1      <= '0;
      r_out_src2      <= '0;
      r_out_src2_used <= 1'b0;
      r_out_dst       <= '0;
      r_out_dst_used  <= 1'b0;
      r_out_imm       <= '0;
      r_out_use_imm   <= 1'b0;
      r_out_do_jump   <= 1'b0;
      r_out_jump_addr <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid     <= 1'b1;
      r_out_pc        <= bus.in_pc;
      r_out_src1      <= w_src1;
      r_out_src2      <= w_src2;
      r_out_src2_used <= w_src2_used;
      r_out_dst       <= w_dst;
      r_out_dst_used  <= w_dst_used;
      r_out_imm       <= w_imm;
      r_out_use_imm   <= w_use_imm;
      r_out_do_jump   <= w_do_jump;
      r_out_jump_addr <= w_jump_addr;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.hazard_stall  = w_hazard;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out_pc;
  assign bus.out_src1      = r_out_src1;
  assign bus.out_src2      = r_out_src2;
  assign bus.out_src2_used = r_out_src2_used;
  assign bus.out_dst       = r_out_dst;
  assign bus.out_dst_used  = r_out_dst_used;
  assign bus.out_imm       = r_out_imm;
  assign bus.out_use_imm   = r_out_use_imm;
  assign bus.out_do_jump   = r_out_do_jump;
  assign bus.out_jump_addr = r_out_jump_addr;

endmodule
